// File: rtl/clk_div_ctrl.sv
// Programmable clock-divider controller: derives a glitch-free divided clock bclk
// and a per-period tick from mclk, with start/stop and divisor changes on period boundaries.
module clk_div_ctrl #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_req,
    input  logic [DIV_W-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic             bclk,
    output logic             tick,
    output logic             running,
    output logic [DIV_W-1:0] cur_div
);

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] div_nxt;
    logic [DIV_W-1:0] new_div, new_div_nxt;
    logic [DIV_W-1:0] req_div;
    logic [DIV_W-1:0] last_cnt;
    logic             pending, pending_nxt;
    logic             req_busy;
    logic             accept, have_req, at_end;
    logic             ack_nxt, err_nxt, bclk_nxt, tick_nxt;

    // A request is only fresh once div_req has been seen low after the previous one.
    assign accept   = div_req && !pending && !req_busy;
    assign have_req = pending || accept;
    assign req_div  = pending ? new_div : div_val;
    assign last_cnt = cur_div - DIV_W'(1);
    assign at_end   = (state != IDLE) && (cnt == last_cnt);
    assign running  = (state != IDLE);

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latch).
        state_nxt   = state;
        cnt_nxt     = cnt;
        div_nxt     = cur_div;
        new_div_nxt = new_div;
        pending_nxt = 1'b0;
        ack_nxt     = 1'b0;
        err_nxt     = 1'b0;

        if (have_req) begin
            if (req_div < DIV_W'(2)) begin
                ack_nxt = 1'b1;
                err_nxt = 1'b1;
            end else if (state == IDLE || at_end) begin
                ack_nxt = 1'b1;
                div_nxt = req_div;
            end else begin
                pending_nxt = 1'b1;
                new_div_nxt = req_div;
            end
        end

        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                cnt_nxt = at_end ? '0 : cnt + DIV_W'(1);
                if (!en) state_nxt = STOPPING;
            end
            STOPPING: begin
                cnt_nxt = at_end ? '0 : cnt + DIV_W'(1);
                if (en)          state_nxt = RUN;
                else if (at_end) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Outputs are registered from next-state values so they line up with cnt/state.
        bclk_nxt = (state_nxt != IDLE) && (cnt_nxt < (div_nxt >> 1));
        tick_nxt = (state_nxt != IDLE) && (cnt_nxt == '0);
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_div  <= DIV_W'(DEFAULT_DIV);
            new_div  <= DIV_W'(DEFAULT_DIV);
            pending  <= 1'b0;
            req_busy <= 1'b0;
            bclk     <= 1'b0;
            tick     <= 1'b0;
            div_ack  <= 1'b0;
            div_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cur_div  <= div_nxt;
            new_div  <= new_div_nxt;
            pending  <= pending_nxt;
            req_busy <= div_req && (req_busy || accept);
            bclk     <= bclk_nxt;
            tick     <= tick_nxt;
            div_ack  <= ack_nxt;
            div_err  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus randomized en/divisor
// traffic, compared cycle by cycle against a phase-based behavioural model.
module tb_clk_div_ctrl;

    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 4;
    localparam int M_IDLE      = 0;
    localparam int M_RUN       = 1;
    localparam int M_STOP      = 2;
    localparam int BOUND       = 600;

    logic             mclk;
    logic             rst_n;
    logic             en;
    logic             div_req;
    logic [DIV_W-1:0] div_val;
    logic             div_ack;
    logic             div_err;
    logic             bclk;
    logic             tick;
    logic             running;
    logic [DIV_W-1:0] cur_div;

    int errors = 0;
    int checks = 0;

    // Model: mode, position within the period, divisor, handshake bookkeeping.
    int m_mode, m_phase, m_n, m_want;
    bit m_pend, m_hold;
    bit exp_bclk, exp_tick, exp_ack, exp_err;

    clk_div_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .mclk    (mclk),
        .rst_n   (rst_n),
        .en      (en),
        .div_req (div_req),
        .div_val (div_val),
        .div_ack (div_ack),
        .div_err (div_err),
        .bclk    (bclk),
        .tick    (tick),
        .running (running),
        .cur_div (cur_div)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_mode = M_IDLE; m_phase = 0; m_n = DEFAULT_DIV; m_want = 0;
        m_pend = 0; m_hold = 0;
        exp_bclk = 0; exp_tick = 0; exp_ack = 0; exp_err = 0;
    endtask

    task automatic model_edge();
        bit fresh, have, wrap;
        int want, n_after;
        fresh   = div_req && !m_pend && !m_hold;
        have    = m_pend || fresh;
        want    = m_pend ? m_want : int'(div_val);
        wrap    = (m_mode != M_IDLE) && (m_phase == m_n - 1);
        m_hold  = div_req && (m_hold || fresh);
        exp_ack = 0; exp_err = 0; n_after = m_n; m_pend = 0;
        if (have) begin
            if (want < 2) begin
                exp_ack = 1; exp_err = 1;
            end else if (m_mode == M_IDLE || wrap) begin
                exp_ack = 1; n_after = want;
            end else begin
                m_pend = 1; m_want = want;
            end
        end
        if (m_mode == M_IDLE) begin
            if (en) begin m_mode = M_RUN; m_phase = 0; end
        end else begin
            m_phase = (m_phase + 1) % m_n;
            if (en)                          m_mode = M_RUN;
            else if (m_mode == M_STOP && wrap) begin m_mode = M_IDLE; m_phase = 0; end
            else                             m_mode = M_STOP;
        end
        m_n      = n_after;
        exp_bclk = (m_mode != M_IDLE) && (m_phase < m_n / 2);
        exp_tick = (m_mode != M_IDLE) && (m_phase == 0);
    endtask

    // Advance one mclk, update the model, and compare every output 1 ns after the edge.
    task automatic step_and_compare();
        @(posedge mclk);
        model_edge();
        #1;
        checks++;
        if (bclk !== exp_bclk) begin errors++; $display("FAIL model_bclk: got %b want %b t=%0t", bclk, exp_bclk, $time); end
        checks++;
        if (tick !== exp_tick) begin errors++; $display("FAIL model_tick: got %b want %b t=%0t", tick, exp_tick, $time); end
        checks++;
        if (running !== (m_mode != M_IDLE)) begin errors++; $display("FAIL model_running: got %b want %b t=%0t", running, (m_mode != M_IDLE), $time); end
        checks++;
        if (cur_div !== DIV_W'(m_n)) begin errors++; $display("FAIL model_cur_div: got %0d want %0d t=%0t", cur_div, m_n, $time); end
        checks++;
        if (div_ack !== exp_ack) begin errors++; $display("FAIL model_ack: got %b want %b t=%0t", div_ack, exp_ack, $time); end
        checks++;
        if (div_err !== exp_err) begin errors++; $display("FAIL model_err: got %b want %b t=%0t", div_err, exp_err, $time); end
    endtask

    // Step until a tick is observed (cnt==0), then k more cycles.
    task automatic wait_phase(input int k);
        bit seen = 0;
        for (int i = 0; i < BOUND && !seen; i++) begin
            step_and_compare();
            seen = tick;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL wait_tick: got no tick want tick within %0d cycles", BOUND); end
        for (int i = 0; i < k; i++) step_and_compare();
    endtask

    task automatic do_request(input int val);
        bit got = 0;
        div_req = 1'b1;
        div_val = DIV_W'(val);
        for (int i = 0; i < BOUND && !got; i++) begin
            step_and_compare();
            got = div_ack;
        end
        div_req = 1'b0;
        checks++;
        if (!got) begin errors++; $display("FAIL req_ack_timeout: got no ack want ack for div %0d", val); end
        step_and_compare();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; div_req = 1'b0; div_val = '0;
        model_reset();
        #12;
        checks++;
        if (bclk !== 1'b0 || tick !== 1'b0 || running !== 1'b0 || div_ack !== 1'b0 || div_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got bclk=%b tick=%b run=%b ack=%b err=%b want all 0", bclk, tick, running, div_ack, div_err);
        end
        checks++;
        if (cur_div !== DIV_W'(DEFAULT_DIV)) begin errors++; $display("FAIL reset_cur_div: got %0d want %0d", cur_div, DEFAULT_DIV); end
        @(posedge mclk); #1;
        rst_n = 1'b1;
        step_and_compare();
    endtask

    task automatic test_run_div4();
        bit pat [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step_and_compare();
            checks++;
            if (bclk !== pat[i % 4]) begin errors++; $display("FAIL run4_bclk: got %b want %b cycle %0d", bclk, pat[i % 4], i); end
            checks++;
            if (tick !== (i % 4 == 0)) begin errors++; $display("FAIL run4_tick: got %b want %b cycle %0d", tick, (i % 4 == 0), i); end
        end
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL run4_running: got %b want 1", running); end
    endtask

    task automatic test_bad_div();
        wait_phase(1);
        div_req = 1'b1; div_val = 8'd1;
        step_and_compare();
        checks++;
        if (div_ack !== 1'b1 || div_err !== 1'b1) begin errors++; $display("FAIL bad_div_ack_err: got ack=%b err=%b want 1 1", div_ack, div_err); end
        checks++;
        if (cur_div !== 8'd4) begin errors++; $display("FAIL bad_div_cur_div: got %0d want 4", cur_div); end
        div_req = 1'b0;
        step_and_compare();
        checks++;
        if (div_ack !== 1'b0 || div_err !== 1'b0) begin errors++; $display("FAIL bad_div_pulse: got ack=%b err=%b want 0 0", div_ack, div_err); end
    endtask

    task automatic test_div_change();
        wait_phase(1);
        div_req = 1'b1; div_val = 8'd5;
        step_and_compare();
        div_val = 8'd9;
        checks++;
        if (div_ack !== 1'b0 || cur_div !== 8'd4) begin errors++; $display("FAIL change_early: got ack=%b div=%0d want 0 4", div_ack, cur_div); end
        step_and_compare();
        checks++;
        if (div_ack !== 1'b0 || cur_div !== 8'd4) begin errors++; $display("FAIL change_early2: got ack=%b div=%0d want 0 4", div_ack, cur_div); end
        step_and_compare();
        checks++;
        if (div_ack !== 1'b1 || cur_div !== 8'd5 || tick !== 1'b1) begin
            errors++; $display("FAIL change_apply: got ack=%b div=%0d tick=%b want 1 5 1", div_ack, cur_div, tick);
        end
        div_req = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step_and_compare();
            checks++;
            if (bclk !== (i % 5 < 2) || tick !== (i % 5 == 0)) begin
                errors++; $display("FAIL div5_wave: got bclk=%b tick=%b want %b %b cycle %0d", bclk, tick, (i % 5 < 2), (i % 5 == 0), i);
            end
        end
        do_request(4);
        checks++;
        if (cur_div !== 8'd4) begin errors++; $display("FAIL restore_div4: got %0d want 4", cur_div); end
    endtask

    task automatic test_stop();
        int ticks = 0;
        wait_phase(1);
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step_and_compare();
            checks++;
            if (running !== 1'b1 || bclk !== 1'b0) begin errors++; $display("FAIL stop_tail: got run=%b bclk=%b want 1 0", running, bclk); end
        end
        step_and_compare();
        checks++;
        if (running !== 1'b0 || bclk !== 1'b0 || tick !== 1'b0) begin
            errors++; $display("FAIL stop_idle: got run=%b bclk=%b tick=%b want 0 0 0", running, bclk, tick);
        end
        for (int i = 0; i < 8; i++) begin
            step_and_compare();
            ticks += int'(tick);
        end
        checks++;
        if (ticks != 0) begin errors++; $display("FAIL stop_no_tick: got %0d ticks want 0", ticks); end
        // Drop en at cnt=1, re-raise at cnt=2: the period must run on uninterrupted.
        en = 1'b1;
        step_and_compare();
        step_and_compare();
        en = 1'b0;
        step_and_compare();
        en = 1'b1;
        for (int i = 3; i <= 8; i++) begin
            step_and_compare();
            checks++;
            if (running !== 1'b1 || tick !== (i % 4 == 0)) begin
                errors++; $display("FAIL stop_resume: got run=%b tick=%b want 1 %b cnt %0d", running, tick, (i % 4 == 0), i % 4);
            end
        end
    endtask

    task automatic test_idle_div2();
        bit idle = 0;
        en = 1'b0;
        for (int i = 0; i < BOUND && !idle; i++) begin
            step_and_compare();
            idle = !running;
        end
        checks++;
        if (!idle) begin errors++; $display("FAIL idle_reach: got running want idle within %0d cycles", BOUND); end
        div_req = 1'b1; div_val = 8'd2;
        step_and_compare();
        checks++;
        if (div_ack !== 1'b1 || cur_div !== 8'd2) begin errors++; $display("FAIL idle_div2_ack: got ack=%b div=%0d want 1 2", div_ack, cur_div); end
        div_req = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step_and_compare();
            checks++;
            if (bclk !== (i % 2 == 0) || tick !== (i % 2 == 0)) begin
                errors++; $display("FAIL div2_wave: got bclk=%b tick=%b want %b cycle %0d", bclk, tick, (i % 2 == 0), i);
            end
        end
    endtask

    task automatic test_reset_midrun();
        do_request(6);
        wait_phase(0);
        div_req = 1'b1; div_val = 8'd3;
        step_and_compare();
        #2;
        rst_n = 1'b0;
        div_req = 1'b0;
        en = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bclk !== 1'b0 || tick !== 1'b0 || running !== 1'b0) begin
            errors++; $display("FAIL midrun_reset: got bclk=%b tick=%b run=%b want 0 0 0", bclk, tick, running);
        end
        checks++;
        if (cur_div !== DIV_W'(DEFAULT_DIV)) begin errors++; $display("FAIL midrun_cur_div: got %0d want %0d", cur_div, DEFAULT_DIV); end
        @(posedge mclk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step_and_compare();
            checks++;
            if (div_ack !== 1'b0) begin errors++; $display("FAIL midrun_no_ack: got ack=%b want 0 cycle %0d", div_ack, i); end
        end
    endtask

    task automatic test_random();
        en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) en = ~en;
            if (div_req && div_ack) begin
                div_req = 1'b0;
                div_val = DIV_W'($urandom_range(0, 255));
            end else if (div_req) begin
                if ($urandom_range(0, 3) == 0) div_val = DIV_W'($urandom_range(0, 255));
            end else if ($urandom_range(0, 9) == 0) begin
                div_req = 1'b1;
                div_val = ($urandom_range(0, 7) == 0) ? DIV_W'(255) : DIV_W'($urandom_range(0, 12));
            end
            step_and_compare();
        end
        div_req = 1'b0;
        step_and_compare();
    endtask

    initial begin
        test_reset();
        test_run_div4();
        test_bad_div();
        test_div_change();
        test_stop();
        test_idle_div2();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
